// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared types for the BRAM-backed streaming FIFO controller.
package bram_fifo_ctrl_pkg;

   localparam int BUF_SLOTS = 2;

   typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller driving a dual-port BRAM: port A writes, port B reads,
// and a 2-entry output buffer hides port B's registered read latency.
module bram_fifo_ctrl
   import bram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH+1:0] count,
   output logic                  full,
   output logic                  empty,
   output logic                  ram_en_a,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_din_a,
   output logic                  ram_en_b,
   output logic                  ram_we_b,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   input  logic [DATA_WIDTH-1:0] ram_dout_b
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CAP   = DEPTH + 2;
   localparam int CW    = ADDR_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic                  inflight_p1;
   buf_cnt_t              buf_cnt;
   buf_cnt_t              buf_cnt_popped;
   logic [DATA_WIDTH-1:0] buf_p0;
   logic [DATA_WIDTH-1:0] buf_p1;
   logic [2:0]            occ_after_pop;
   logic                  push;
   logic                  pop;
   logic                  issue;

   assign ram_cnt = wr_ptr - rd_ptr;

   // A push offered during clr still sees s_ready but is dropped with the flush.
   assign s_ready = rst_n && (ram_cnt < DEPTH_V);
   assign push    = s_valid && s_ready && !clr;

   assign m_valid        = (buf_cnt != '0);
   assign m_data         = buf_p0;
   assign pop            = m_valid && m_ready;
   assign buf_cnt_popped = buf_cnt - buf_cnt_t'(pop);

   // Issue only if the word can land in the buffer next cycle, counting the one already in flight.
   assign occ_after_pop = 3'(buf_cnt) + 3'(inflight_p1) - 3'(pop);
   assign issue         = rst_n && !clr && (ram_cnt != '0) && (occ_after_pop <= 3'(BUF_SLOTS - 1));

   assign count = CW'(ram_cnt) + CW'(inflight_p1) + CW'(buf_cnt);
   assign full  = (count == CW'(CAP));
   assign empty = (count == '0);

   assign ram_en_a   = push;
   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_din_a  = s_data;
   assign ram_en_b   = issue;
   assign ram_we_b   = 1'b0;
   assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];

   // Stage p0 -> p1: pointer bookkeeping and read-issue tracking
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         inflight_p1 <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         inflight_p1 <= issue;
      end
   end

   // Stage p1 -> output: capture RAM read data into the first free slot after the pop
   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         buf_cnt <= '0;
      else
         buf_cnt <= buf_cnt_popped + buf_cnt_t'(inflight_p1);

      if (pop)
         buf_p0 <= buf_p1;
      if (inflight_p1) begin
         if (buf_cnt_popped == '0)
            buf_p0 <= ram_dout_b;
         else
            buf_p1 <= ram_dout_b;
      end
   end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural dual-port RAM attached.
module tb_bram_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n, clr, s_valid, s_ready, m_valid, m_ready;
   logic [DW-1:0] s_data, m_data;
   logic [AW+1:0] count;
   logic          full, empty;
   logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_din_a, ram_dout_b;
   logic [DW-1:0] mem [16];

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .count(count), .full(full), .empty(empty),
      .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
      .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
   );

   always @(posedge clk) begin
      if (ram_en_a && ram_we_a)
         mem[ram_addr_a] <= ram_din_a;
      if (ram_en_b && !ram_we_b)
         ram_dout_b <= mem[ram_addr_b];
   end

   typedef struct {
      logic          rst_n, clr, s_valid;
      logic [DW-1:0] s_data;
      logic          m_ready;
      logic          e_s_ready, e_en_a, e_en_b, e_m_valid;
      logic [DW-1:0] e_m_data;
      logic [AW+1:0] e_count;
      logic          e_empty, e_full;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      int accepted;
      int expo;
      int pushed;
      int w;
      logic [DW-1:0] q [$];
      logic [8:0] qexp;

      rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);

      //         rst clr sv  data   mr | srdy enA enB mv  mdata  cnt  emp full
      vt[0] = '{1'b0,1'b0,1'b1,8'h11,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};
      vt[1] = '{1'b0,1'b0,1'b1,8'h22,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};
      vt[2] = '{1'b1,1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b1,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};
      vt[3] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b1,1'b0,8'h00,6'd1,1'b0,1'b0};
      vt[4] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,6'd1,1'b0,1'b0};
      vt[5] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,1'b1,8'hA5,6'd1,1'b0,1'b0};
      vt[6] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};
      vt[7] = '{1'b1,1'b1,1'b1,8'h77,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};
      vt[8] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,6'd0,1'b1,1'b0};

      for (int i = 0; i < 9; i++) begin
         rst_n = vt[i].rst_n; clr = vt[i].clr; s_valid = vt[i].s_valid;
         s_data = vt[i].s_data; m_ready = vt[i].m_ready;
         #1;
         chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vt[i].e_s_ready));
         chk($sformatf("v%0d_ram_en_a", i), 32'(ram_en_a), 32'(vt[i].e_en_a));
         chk($sformatf("v%0d_ram_en_b", i), 32'(ram_en_b), 32'(vt[i].e_en_b));
         chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vt[i].e_m_valid));
         if (vt[i].e_m_valid)
            chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vt[i].e_m_data));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_count));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].e_full));
         @(negedge clk);
      end

      // Fill to capacity with the sink stalled
      accepted = 0;
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1; s_data = DW'(i);
         #1;
         if (s_ready) accepted++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("fill_accepted", 32'(accepted), 32'd18);
      chk("fill_s_ready", 32'(s_ready), 32'd0);
      chk("fill_count", 32'(count), 32'd18);
      chk("fill_full", 32'(full), 32'd1);
      @(negedge clk);
      m_ready = 1'b1;
      for (int j = 0; j < 18; j++) begin
         #1;
         w = 0;
         while (!m_valid && w < 10) begin
            @(negedge clk); #1; w++;
         end
         chk("fill_pop_valid", 32'(m_valid), 32'd1);
         chk("fill_pop_data", 32'(m_data), 32'(j));
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      #1;
      chk("fill_drained_empty", 32'(empty), 32'd1);
      @(negedge clk);

      // Streaming at full rate
      expo = 0;
      for (int c = 0; c < 100; c++) begin
         s_valid = 1'b1; s_data = DW'(c); m_ready = 1'b1;
         #1;
         chk("stream_s_ready", 32'(s_ready), 32'd1);
         if (c >= 3) begin
            chk("stream_m_valid", 32'(m_valid), 32'd1);
            chk("stream_count", 32'(count), 32'd3);
         end
         if (m_valid) begin
            chk("stream_data", 32'(m_data), 32'(expo[DW-1:0]));
            expo++;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (m_valid) begin
            chk("stream_drain_data", 32'(m_data), 32'(expo[DW-1:0]));
            expo++;
         end
         @(negedge clk);
      end
      #1;
      chk("stream_total", 32'(expo), 32'd100);
      chk("stream_empty", 32'(empty), 32'd1);
      @(negedge clk);

      // Random backpressure across pointer wrap
      pushed = 0;
      for (int c = 0; c < 400 && !(pushed == 40 && q.size() == 0); c++) begin
         s_valid = (pushed < 40);
         s_data  = DW'(8'h80 + pushed);
         m_ready = 1'($urandom_range(0, 1));
         #1;
         chk("wrap_count_le_cap", 32'(count <= 6'd18), 32'd1);
         if (s_valid && s_ready) begin
            q.push_back(s_data);
            pushed++;
         end
         if (m_valid && m_ready) begin
            qexp = (q.size() != 0) ? {1'b0, q.pop_front()} : 9'h1FF;
            chk("wrap_data", 32'({1'b0, m_data}), 32'(qexp));
         end
         @(negedge clk);
      end
      s_valid = 1'b0; m_ready = 1'b0;
      #1;
      chk("wrap_pushed", 32'(pushed), 32'd40);
      chk("wrap_leftover", 32'(q.size()), 32'd0);
      chk("wrap_empty", 32'(empty), 32'd1);
      @(negedge clk);

      // Flush with a read in flight
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = DW'(8'h50 + i);
         #1;
         chk("flush_load_ready", 32'(s_ready), 32'd1);
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      m_ready = 1'b1;
      #1;
      chk("flush_head_valid", 32'(m_valid), 32'd1);
      chk("flush_head_data", 32'(m_data), 32'h50);
      chk("flush_issue", 32'(ram_en_b), 32'd1);
      @(negedge clk);
      m_ready = 1'b0; clr = 1'b1;
      #1;
      chk("flush_pre_count", 32'(count), 32'd9);
      chk("flush_issue_blocked", 32'(ram_en_b), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_m_valid", 32'(m_valid), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
      #1;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      w = 0;
      while (!m_valid && w < 10) begin
         @(negedge clk); #1; w++;
      end
      chk("flush_next_valid", 32'(m_valid), 32'd1);
      chk("flush_next_data", 32'(m_data), 32'h3C);
      @(negedge clk);
      #1;
      chk("flush_final_empty", 32'(empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
